palette_ram_arbiter: RTL and testbench

Shares the single-port palette RAM between the video colour lookup and the 68000 bus. CPU writes are posted into a small FIFO and drained in free RAM slots; CPU reads stall until the FIFO has drained. Video fetches own the RAM during active display. It sits between the CPU address decoder and the palette block RAM. The existing palette DAC then takes the `vid_data` word.

---
 rtl/palette_pkg.sv | 22 ++
 rtl/palette_ram_arbiter_if.sv | 24 ++
 rtl/palette_wr_fifo.sv | 47 ++++
 rtl/palette_ram_arbiter.sv | 170 +++++++++++++++++
 tb/tb_palette_ram_arbiter.sv | 275 +++++++++++++++++++++++++++
 5 files changed

// File: rtl/palette_pkg.sv
// Shared widths and types for the palette RAM arbiter and its write FIFO.
package palette_pkg;

  localparam int unsigned PAL_AW = 14;
  localparam int unsigned PAL_DW = 16;

  typedef struct packed {
    logic [PAL_AW-1:0] addr;
    logic [PAL_DW-1:0] data;
    logic              be_h;
    logic              be_l;
  } wr_entry_t;

  typedef enum logic [2:0] {
    IDLE,
    RD_WAIT,
    RD_ISSUE,
    RD_DONE,
    ACK
  } arb_state_t;

endpackage

// File: rtl/palette_ram_arbiter_if.sv
// 68000-side palette bus: the CPU (master) drives strobes, the arbiter (slave) answers.
interface palette_ram_arbiter_if;
  import palette_pkg::*;

  logic              cpu_cs;
  logic [PAL_AW-1:0] cpu_addr;
  logic [PAL_DW-1:0] cpu_din;
  logic [PAL_DW-1:0] cpu_dout;
  logic              cpu_rw_n;
  logic              cpu_uds_n;
  logic              cpu_lds_n;
  logic              cpu_dtack_n;

  modport master (
    output cpu_cs, cpu_addr, cpu_din, cpu_rw_n, cpu_uds_n, cpu_lds_n,
    input  cpu_dout, cpu_dtack_n
  );

  modport slave (
    input  cpu_cs, cpu_addr, cpu_din, cpu_rw_n, cpu_uds_n, cpu_lds_n,
    output cpu_dout, cpu_dtack_n
  );

endinterface

// File: rtl/palette_wr_fifo.sv
// Posted-write FIFO; show-ahead read, and a push is accepted while full if a pop happens that clk.
module palette_wr_fifo
  import palette_pkg::*;
#(
  parameter int unsigned DEPTH = 4
) (
  input  logic      clk,
  input  logic      reset,
  input  logic      push_i,
  input  wr_entry_t push_data_i,
  input  logic      pop_i,
  output wr_entry_t pop_data_o,
  output logic      full_o,
  output logic      empty_o
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned PW = AW + 1;

  wr_entry_t     mem_q [DEPTH];
  logic [PW-1:0] wr_ptr_q;
  logic [PW-1:0] rd_ptr_q;
  logic          do_push;
  logic          do_pop;

  // Extra pointer bit tells full from empty when the indices match.
  assign empty_o    = (wr_ptr_q == rd_ptr_q);
  assign full_o     = (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]) && (wr_ptr_q[AW] != rd_ptr_q[AW]);
  assign do_pop     = pop_i && !empty_o;
  assign do_push    = push_i && (!full_o || do_pop);
  assign pop_data_o = mem_q[rd_ptr_q[AW-1:0]];

  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else begin
      if (do_push) wr_ptr_q <= wr_ptr_q + PW'(1);
      if (do_pop)  rd_ptr_q <= rd_ptr_q + PW'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_ptr_q[AW-1:0]] <= push_data_i;
  end

endmodule

// File: rtl/palette_ram_arbiter.sv
// Shares the single-port palette RAM between video lookup and the 68000 bus;
// CPU writes are posted through a FIFO and drained in granted CPU slots.
module palette_ram_arbiter
  import palette_pkg::*;
#(
  parameter int unsigned FIFO_DEPTH = 4
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 ce_double,
  input  logic                 ce_pixel,
  input  logic                 HBLANKn,
  input  logic                 VBLANKn,
  input  logic                 ACCMODE,
  palette_ram_arbiter_if.slave cpu,
  input  logic [PAL_AW-1:0]    vid_addr,
  output logic [PAL_DW-1:0]    vid_data,
  output logic [PAL_AW-1:0]    ram_addr,
  output logic [PAL_DW-1:0]    ram_din,
  input  logic [PAL_DW-1:0]    ram_dout,
  output logic                 ram_we_l_n,
  output logic                 ram_we_h_n
);

  arb_state_t        state_q;
  logic              dtack_n_q;
  logic [PAL_DW-1:0] dout_q;
  logic [PAL_AW-1:0] ram_addr_q;
  logic [PAL_DW-1:0] ram_din_q;
  logic              ram_we_h_n_q;
  logic              ram_we_l_n_q;
  logic              vid_slot_q;
  logic              vid_ok_q;
  logic [PAL_DW-1:0] vid_hold_q;
  logic [PAL_DW-1:0] vid_data_q;

  logic              disp_active;
  logic              cpu_slot;
  logic              wr_req;
  logic              wr_null;
  logic              wr_ack;
  logic              push;
  logic              pop;
  logic              rd_issue;
  logic              fifo_full;
  logic              fifo_empty;
  wr_entry_t         push_entry;
  wr_entry_t         pop_entry;
  logic [PAL_DW-1:0] vid_prev;

  // Slot arbitration: pops beat read issue, so reads see every earlier write.
  assign disp_active = HBLANKn && VBLANKn;
  assign cpu_slot    = ce_double && !ce_pixel && (!disp_active || ACCMODE);
  assign pop         = cpu_slot && !fifo_empty;
  assign rd_issue    = (state_q == RD_WAIT) && cpu_slot && fifo_empty;

  assign wr_req  = (state_q == IDLE) && cpu.cpu_cs && !cpu.cpu_rw_n;
  assign wr_null = cpu.cpu_uds_n && cpu.cpu_lds_n;
  assign push    = wr_req && !wr_null && (!fifo_full || pop);
  assign wr_ack  = wr_req && (wr_null || !fifo_full || pop);

  always_comb begin
    push_entry      = '0;
    push_entry.addr = cpu.cpu_addr;
    push_entry.data = cpu.cpu_din;
    push_entry.be_h = !cpu.cpu_uds_n;
    push_entry.be_l = !cpu.cpu_lds_n;
  end

  palette_wr_fifo #(
    .DEPTH (FIFO_DEPTH)
  ) u_wr_fifo (
    .clk         (clk),
    .reset       (reset),
    .push_i      (push),
    .push_data_i (push_entry),
    .pop_i       (pop),
    .pop_data_o  (pop_entry),
    .full_o      (fifo_full),
    .empty_o     (fifo_empty)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= IDLE;
      dtack_n_q <= 1'b1;
      dout_q    <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (wr_ack) begin
            state_q   <= ACK;
            dtack_n_q <= 1'b0;
          end else if (cpu.cpu_cs && cpu.cpu_rw_n) begin
            state_q <= RD_WAIT;
          end
        end
        RD_WAIT: begin
          if (rd_issue) state_q <= RD_ISSUE;
        end
        RD_ISSUE: begin
          // Address has been held a full slot, so 1-clk RAM latency is covered.
          if (ce_double) begin
            state_q   <= RD_DONE;
            dout_q    <= ram_dout;
            dtack_n_q <= 1'b0;
          end
        end
        RD_DONE, ACK: begin
          if (!cpu.cpu_cs) begin
            state_q   <= IDLE;
            dtack_n_q <= 1'b1;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  // RAM port only changes on slot ticks; write enables last exactly one slot.
  always_ff @(posedge clk) begin
    if (reset) begin
      ram_addr_q   <= '0;
      ram_din_q    <= '0;
      ram_we_h_n_q <= 1'b1;
      ram_we_l_n_q <= 1'b1;
    end else if (ce_double) begin
      ram_we_h_n_q <= 1'b1;
      ram_we_l_n_q <= 1'b1;
      if (pop) begin
        ram_addr_q   <= pop_entry.addr;
        ram_din_q    <= pop_entry.data;
        ram_we_h_n_q <= !pop_entry.be_h;
        ram_we_l_n_q <= !pop_entry.be_l;
      end else if (rd_issue) begin
        ram_addr_q <= cpu.cpu_addr;
      end else begin
        ram_addr_q <= vid_addr;
      end
    end
  end

  // Video word is captured at the tick after its slot, since a CPU slot may follow.
  assign vid_prev = vid_slot_q ? ram_dout : vid_hold_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      vid_slot_q <= 1'b0;
      vid_ok_q   <= 1'b0;
      vid_hold_q <= '0;
      vid_data_q <= '0;
    end else if (ce_double) begin
      vid_slot_q <= ce_pixel;
      if (vid_slot_q) vid_hold_q <= ram_dout;
      if (ce_pixel) begin
        vid_ok_q   <= disp_active && !ACCMODE;
        vid_data_q <= vid_ok_q ? vid_prev : '0;
      end
    end
  end

  assign cpu.cpu_dout    = dout_q;
  assign cpu.cpu_dtack_n = dtack_n_q;
  assign vid_data        = vid_data_q;
  assign ram_addr        = ram_addr_q;
  assign ram_din         = ram_din_q;
  assign ram_we_h_n      = ram_we_h_n_q;
  assign ram_we_l_n      = ram_we_l_n_q;

endmodule

// File: tb/tb_palette_ram_arbiter.sv
// Scoreboard bench for palette_ram_arbiter: directed CPU/video stimulus, behavioural palette RAM.
module tb_palette_ram_arbiter;

  typedef struct {
    bit          rd;
    logic [15:0] data;
    int          lat;
  } cpu_exp_t;

  logic        clk;
  logic        reset;
  logic        ce_double;
  logic        ce_pixel;
  logic        hblank_n;
  logic        vblank_n;
  logic        accmode;
  logic [13:0] vid_addr;
  logic [15:0] vid_data;
  logic [13:0] ram_addr;
  logic [15:0] ram_din;
  logic [15:0] ram_dout;
  logic        ram_we_l_n;
  logic        ram_we_h_n;
  logic [1:0]  ph;

  palette_ram_arbiter_if bus ();

  palette_ram_arbiter #(.FIFO_DEPTH(4)) dut (
    .clk        (clk),
    .reset      (reset),
    .ce_double  (ce_double),
    .ce_pixel   (ce_pixel),
    .HBLANKn    (hblank_n),
    .VBLANKn    (vblank_n),
    .ACCMODE    (accmode),
    .cpu        (bus),
    .vid_addr   (vid_addr),
    .vid_data   (vid_data),
    .ram_addr   (ram_addr),
    .ram_din    (ram_din),
    .ram_dout   (ram_dout),
    .ram_we_l_n (ram_we_l_n),
    .ram_we_h_n (ram_we_h_n)
  );

  int n_checks;
  int n_pass;
  int cyc;
  int cs_start;
  cpu_exp_t    cpu_q[$];
  logic [31:0] ram_q[$];
  logic [15:0] vid_q[$];

  logic [15:0] mem [16384];
  bit          init_done;
  bit          pix_seen;
  logic        prev_dtack_n = 1'b1;
  logic        prev_wr_act  = 1'b0;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) begin
    cyc      <= cyc + 1;
    pix_seen <= ce_pixel;
  end

  // Palette RAM model: 1-clk read latency, byte write enables.
  always @(posedge clk) begin
    if (!ram_we_h_n) mem[ram_addr][15:8] <= ram_din[15:8];
    if (!ram_we_l_n) mem[ram_addr][7:0]  <= ram_din[7:0];
    ram_dout <= mem[ram_addr];
    if (!init_done) begin
      for (int i = 0; i < 16384; i++) mem[i] <= 16'h0000;
      mem[5]    <= 16'hF0F0;
      mem[6]    <= 16'h1111;
      init_done <= 1'b1;
    end
  end

  // Slot strobes: ce_double every 2 clk, every other one is a pixel.
  initial begin
    ph = 2'd3; ce_double = 1'b0; ce_pixel = 1'b0;
    forever begin
      @(posedge clk); #1;
      ph        = ph + 2'd1;
      ce_double = (ph[0] == 1'b0);
      ce_pixel  = (ph == 2'd0);
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", name, act, exp, $time);
  endtask

  // Monitor: CPU acknowledges, RAM write bursts and pixel outputs against the queues.
  always @(negedge clk) begin
    cpu_exp_t e;
    logic     wr_act;
    if (!reset) begin
      if (prev_dtack_n && !bus.cpu_dtack_n) begin
        if (cpu_q.size() == 0) chk("cpu_q_level", 32'(cpu_q.size()), 32'd1);
        else begin
          e = cpu_q.pop_front();
          if (e.lat >= 0) chk("ack_latency", 32'(cyc - cs_start), 32'(e.lat));
          if (e.rd) chk("rd_data", 32'(bus.cpu_dout), 32'(e.data));
        end
      end
      wr_act = !ram_we_h_n || !ram_we_l_n;
      if (wr_act && !prev_wr_act) begin
        if (ram_q.size() == 0) chk("ram_wr_q_level", 32'(ram_q.size()), 32'd1);
        else chk("ram_wr", {ram_addr, ram_din, ram_we_h_n, ram_we_l_n}, ram_q.pop_front());
      end
      prev_wr_act = wr_act;
      if (pix_seen && vid_q.size() > 0) chk("vid_data", 32'(vid_data), 32'(vid_q.pop_front()));
    end
    prev_dtack_n = bus.cpu_dtack_n;
  end

  task automatic release_bus();
    bus.cpu_cs = 1'b0; bus.cpu_rw_n = 1'b1; bus.cpu_uds_n = 1'b1; bus.cpu_lds_n = 1'b1;
  endtask

  task automatic wait_ack();
    int t = 0;
    while (bus.cpu_dtack_n && t < 400) begin @(negedge clk); t++; end
    if (bus.cpu_dtack_n) chk("dtack_timeout", 32'(bus.cpu_dtack_n), 32'd0);
    release_bus();
    t = 0;
    @(negedge clk);
    while (!bus.cpu_dtack_n && t < 10) begin @(negedge clk); t++; end
    if (!bus.cpu_dtack_n) chk("dtack_release", 32'(bus.cpu_dtack_n), 32'd1);
  endtask

  // Called at a negedge; lat < 0 means the acknowledge latency is not checked.
  task automatic cpu_write(input logic [13:0] a, input logic [15:0] d,
                           input logic u_n, input logic l_n, input int lat);
    cpu_exp_t e;
    bus.cpu_addr = a; bus.cpu_din = d; bus.cpu_rw_n = 1'b0;
    bus.cpu_uds_n = u_n; bus.cpu_lds_n = l_n; bus.cpu_cs = 1'b1;
    cs_start = cyc;
    e.rd = 1'b0; e.data = 16'h0; e.lat = lat;
    cpu_q.push_back(e);
    if (!(u_n && l_n)) ram_q.push_back({a, d, u_n, l_n});
    @(negedge clk);
    wait_ack();
  endtask

  task automatic cpu_read(input logic [13:0] a, input logic [15:0] exp_d);
    cpu_exp_t e;
    bus.cpu_addr = a; bus.cpu_rw_n = 1'b1;
    bus.cpu_uds_n = 1'b0; bus.cpu_lds_n = 1'b0; bus.cpu_cs = 1'b1;
    cs_start = cyc;
    e.rd = 1'b1; e.data = exp_d; e.lat = -1;
    cpu_q.push_back(e);
    @(negedge clk);
    wait_ack();
  endtask

  task automatic check_reset_outputs();
    chk("rst_dtack_n", 32'(bus.cpu_dtack_n), 32'd1);
    chk("rst_cpu_dout", 32'(bus.cpu_dout), 32'd0);
    chk("rst_vid_data", 32'(vid_data), 32'd0);
    chk("rst_ram_addr", 32'(ram_addr), 32'd0);
    chk("rst_ram_din", 32'(ram_din), 32'd0);
    chk("rst_ram_we", 32'({ram_we_h_n, ram_we_l_n}), 32'd3);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int t;
    reset = 1'b1; hblank_n = 1'b1; vblank_n = 1'b1; accmode = 1'b0;
    vid_addr = 14'h0005; bus.cpu_addr = '0; bus.cpu_din = '0;
    release_bus();
    repeat (4) @(negedge clk);
    check_reset_outputs();
    reset = 1'b0;
    repeat (4) @(negedge clk);

    // Write in horizontal blanking.
    hblank_n = 1'b0;
    cpu_write(14'h0010, 16'h1234, 1'b0, 1'b0, 1);
    repeat (20) @(negedge clk);
    chk("mem_0010", 32'(mem[14'h0010]), 32'h1234);

    // Both strobes high: acknowledged, never written.
    cpu_write(14'h0060, 16'hDEAD, 1'b1, 1'b1, 1);
    repeat (20) @(negedge clk);
    chk("mem_0060_untouched", 32'(mem[14'h0060]), 32'h0000);

    // Five writes during active display: FIFO fills, fifth waits for blanking.
    hblank_n = 1'b1;
    for (int i = 0; i < 4; i++) cpu_write(14'h0040 + 14'(i), 16'h1000 + 16'(i), 1'b0, 1'b0, 1);
    fork
      cpu_write(14'h0044, 16'h1004, 1'b0, 1'b0, -1);
      begin
        repeat (20) @(negedge clk);
        chk("w5_stalled", 32'(bus.cpu_dtack_n), 32'd1);
        hblank_n = 1'b0;
      end
    join
    repeat (60) @(negedge clk);
    for (int i = 0; i < 5; i++) chk("mem_fifo_order", 32'(mem[14'h0040 + 14'(i)]), 32'h1000 + 32'(i));

    // Read right behind a posted write to the same address.
    cpu_write(14'h0020, 16'h5A5A, 1'b0, 1'b0, 1);
    cpu_read(14'h0020, 16'h5A5A);

    // Upper-byte-only write merges with existing low byte.
    cpu_write(14'h0030, 16'h00CD, 1'b0, 1'b0, 1);
    cpu_write(14'h0030, 16'hAB00, 1'b0, 1'b1, 1);
    cpu_read(14'h0030, 16'hABCD);

    // Video: active display with ACCMODE=0 shows the palette word.
    hblank_n = 1'b1; accmode = 1'b0; vid_addr = 14'h0005;
    repeat (16) @(negedge clk);
    vid_q.push_back(16'hF0F0);
    repeat (8) @(negedge clk);

    // One-pixel lag: change index right before a pixel tick.
    t = 0;
    while (!ce_pixel && t < 8) begin @(negedge clk); t++; end
    vid_addr = 14'h0006;
    vid_q.push_back(16'hF0F0);
    vid_q.push_back(16'h1111);
    repeat (12) @(negedge clk);
    vid_addr = 14'h0005;

    accmode = 1'b1;
    repeat (16) @(negedge clk);
    vid_q.push_back(16'h0000);
    repeat (8) @(negedge clk);

    accmode = 1'b0; hblank_n = 1'b0;
    repeat (16) @(negedge clk);
    vid_q.push_back(16'h0000);
    repeat (8) @(negedge clk);

    // Reset with three posted writes and a stalled read.
    hblank_n = 1'b1;
    repeat (16) @(negedge clk);
    for (int i = 0; i < 3; i++) begin
      cpu_write(14'h0050 + 14'(i), 16'h7770 + 16'(i), 1'b0, 1'b0, 1);
      void'(ram_q.pop_back());
    end
    bus.cpu_addr = 14'h0010; bus.cpu_rw_n = 1'b1;
    bus.cpu_uds_n = 1'b0; bus.cpu_lds_n = 1'b0; bus.cpu_cs = 1'b1;
    repeat (8) @(negedge clk);
    reset = 1'b1;
    release_bus();
    @(negedge clk);
    check_reset_outputs();
    repeat (2) @(negedge clk);
    reset = 1'b0;
    hblank_n = 1'b0;
    repeat (40) @(negedge clk);
    for (int i = 0; i < 3; i++) chk("mem_discarded", 32'(mem[14'h0050 + 14'(i)]), 32'h0000);
    cpu_read(14'h0010, 16'h1234);
    repeat (10) @(negedge clk);

    chk("cpu_q_drained", 32'(cpu_q.size()), 32'd0);
    chk("ram_q_drained", 32'(ram_q.size()), 32'd0);
    chk("vid_q_drained", 32'(vid_q.size()), 32'd0);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
